// File: rtl/sequential_shifter_if.sv
// Request/response bundle for the multi-cycle shifter.
//   master (CPU side): drives START, SHIFT_OP, OPERAND, SHIFT_AMOUNT;
//                      observes RESULT, CARRY, BUSY, DONE.
//   slave  (shifter) : the mirror image.
interface sequential_shifter_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [1:0]       SHIFT_OP;
  logic [WIDTH-1:0] OPERAND;
  logic [7:0]       SHIFT_AMOUNT;
  logic [WIDTH-1:0] RESULT;
  logic             CARRY;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, SHIFT_OP, OPERAND, SHIFT_AMOUNT,
    input  RESULT, CARRY, BUSY, DONE
  );

  modport slave (
    input  START, SHIFT_OP, OPERAND, SHIFT_AMOUNT,
    output RESULT, CARRY, BUSY, DONE
  );
endinterface

// File: rtl/sequential_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous, active-high; returns to IDLE and clears outputs
//   bus   - slave side of sequential_shifter_if:
//           START/SHIFT_OP/OPERAND/SHIFT_AMOUNT in, RESULT/CARRY/BUSY/DONE out
// SHIFT_OP: 00=LSL 01=LSR 10=ASR 11=ROR. Shifts saturate at WIDTH positions;
// rotates use the amount modulo WIDTH.
module sequential_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  sequential_shifter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);  // counter holds 0..WIDTH
  localparam int LW = $clog2(WIDTH);      // rotate amount bits

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR} op_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op, w_op_nxt;
  logic [WIDTH-1:0]  r_res, w_res_nxt;
  logic              r_carry, w_carry_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [CW-1:0]     w_load_cnt;
  logic              w_accept;

  // Counts beyond WIDTH would only shift in more of the same fill, so shifts
  // saturate; rotates are periodic in WIDTH.
  always_comb begin
    w_load_cnt = '0;
    if (op_t'(bus.SHIFT_OP) == OP_ROR)
      w_load_cnt = CW'(bus.SHIFT_AMOUNT[LW-1:0]);
    else if (bus.SHIFT_AMOUNT > 8'(WIDTH))
      w_load_cnt = CW'(WIDTH);
    else
      w_load_cnt = CW'(bus.SHIFT_AMOUNT);
  end

  // A new request may land in DONE as well as IDLE, giving back-to-back ops.
  assign w_accept = bus.START && (r_state != S_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_res_nxt   = r_res;
    w_carry_nxt = r_carry;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      S_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          case (r_op)
            OP_LSL: begin
              w_carry_nxt = r_res[WIDTH-1];
              w_res_nxt   = {r_res[WIDTH-2:0], 1'b0};
            end
            OP_LSR: begin
              w_carry_nxt = r_res[0];
              w_res_nxt   = {1'b0, r_res[WIDTH-1:1]};
            end
            OP_ASR: begin
              w_carry_nxt = r_res[0];
              w_res_nxt   = {r_res[WIDTH-1], r_res[WIDTH-1:1]};
            end
            default: begin  // OP_ROR
              w_carry_nxt = r_res[0];
              w_res_nxt   = {r_res[0], r_res[WIDTH-1:1]};
            end
          endcase
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_accept) begin
      w_state_nxt = S_SHIFT;
      w_op_nxt    = op_t'(bus.SHIFT_OP);
      w_res_nxt   = bus.OPERAND;
      w_carry_nxt = 1'b0;
      w_cnt_nxt   = w_load_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_op    <= OP_LSL;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_res   <= w_res_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.RESULT = r_res;
  assign bus.CARRY  = r_carry;
  assign bus.BUSY   = (r_state == S_SHIFT);
  assign bus.DONE   = (r_state == S_DONE);

endmodule

// File: tb/tb_sequential_shifter.sv
// Self-checking bench for sequential_shifter: directed cases with literal
// expectations, then randomized traffic checked every cycle against an
// arithmetic reference model.
module tb_sequential_shifter;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  sequential_shifter_if #(.WIDTH(8)) bus ();

  sequential_shifter #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: final {carry, result} and step count straight from the rules.
  function automatic void ref_op(input int op, input int a, input int amt,
                                 output int res, output int car, output int n);
    int sv;
    n   = (op == 3) ? (amt % 8) : ((amt > 8) ? 8 : amt);
    sv  = (a >= 128) ? a - 256 : a;
    res = a;
    car = 0;
    case (op)
      0: begin res = (a << n) & 255; if (n > 0) car = (a >> (8 - n)) & 1; end
      1: begin res = a >> n;         if (n > 0) car = (a >> (n - 1)) & 1; end
      2: begin res = (sv >>> n) & 255; if (n > 0) car = (sv >>> (n - 1)) & 1; end
      default: begin
        res = ((a | (a << 8)) >> n) & 255;
        if (n > 0) car = (res >> 7) & 1;
      end
    endcase
  endfunction

  // ---------------- per-cycle model + compare ----------------
  int  edge_n = 0;
  int  m_end = -1;
  int  m_res = 0, m_car = 0;
  bit  m_init = 1'b0;
  bit  m_busy = 1'b0;

  always @(posedge CLK) begin
    int r, c, n;
    bit exp_done;
    edge_n++;
    if (RESET) begin
      m_init = 1'b1;
      m_end  = -1;
      m_res  = 0;
      m_car  = 0;
    end else if (m_init && bus.START && !m_busy) begin
      ref_op(int'(bus.SHIFT_OP), int'(bus.OPERAND), int'(bus.SHIFT_AMOUNT), r, c, n);
      m_res = r;
      m_car = c;
      m_end = edge_n + n + 1;
    end
    #1;
    if (m_init) begin
      m_busy   = (edge_n < m_end);
      exp_done = (edge_n == m_end);
      check("mon_busy", 32'(bus.BUSY), 32'(m_busy));
      check("mon_done", 32'(bus.DONE), 32'(exp_done));
      if (!m_busy) begin
        check("mon_result", 32'(bus.RESULT), 32'(m_res));
        check("mon_carry",  32'(bus.CARRY),  32'(m_car));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] amt);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.SHIFT_OP = op;
    bus.OPERAND = a;
    bus.SHIFT_AMOUNT = amt;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.OPERAND = 8'($urandom);
    bus.SHIFT_AMOUNT = 8'($urandom);
    bus.SHIFT_OP = 2'($urandom);
  endtask

  // Entered at the negedge after the accepting edge plus lat0 cycles.
  task automatic wait_check(input string name, input int lat0, input logic [7:0] er,
                            input logic ec, input int elat);
    int lat = lat0;
    int busy_cnt = lat0;
    while (!bus.DONE && lat < 300) begin
      if (bus.BUSY) busy_cnt++;
      @(negedge CLK);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(elat));
    check({name, "_busy"}, 32'(busy_cnt), 32'(elat));
    check({name, "_result"}, 32'(bus.RESULT), 32'(er));
    check({name, "_carry"}, 32'(bus.CARRY), 32'(ec));
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] amt, input logic [7:0] er, input logic ec,
                       input int elat);
    start_op(op, a, amt);
    wait_check(name, 0, er, ec, elat);
  endtask

  initial begin
    int r, c, n, done_cnt;
    bus.START = 1'b0;
    bus.SHIFT_OP = 2'b00;
    bus.OPERAND = 8'h00;
    bus.SHIFT_AMOUNT = 8'h00;

    // pin the reference model on hand-worked values
    ref_op(0, 8'h81, 1, r, c, n);   check("ref_lsl", 32'(r*2+c), 32'h05);
    ref_op(2, 8'h90, 3, r, c, n);   check("ref_asr", 32'(r*2+c), 32'h1E4);
    ref_op(3, 8'h01, 9, r, c, n);   check("ref_ror", 32'(r*2+c), 32'h101);
    ref_op(1, 8'hFF, 200, r, c, n); check("ref_lsr_sat", 32'(r*2+c+n*1024), 32'h2001);

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("reset_result", 32'(bus.RESULT), 32'h0);
    check("reset_flags", 32'({bus.CARRY, bus.BUSY, bus.DONE}), 32'h0);

    do_op("lsl_81_1",  2'b00, 8'h81, 8'd1,   8'h02, 1'b1, 2);
    do_op("asr_90_3",  2'b10, 8'h90, 8'd3,   8'hF2, 1'b0, 4);
    do_op("lsr_90_3",  2'b01, 8'h90, 8'd3,   8'h12, 1'b0, 4);
    do_op("ror_01_9",  2'b11, 8'h01, 8'd9,   8'h80, 1'b1, 2);
    do_op("ror_a5_8",  2'b11, 8'hA5, 8'd8,   8'hA5, 1'b0, 1);
    do_op("lsr_ff_200",2'b01, 8'hFF, 8'd200, 8'h00, 1'b1, 9);
    do_op("asr_80_255",2'b10, 8'h80, 8'd255, 8'hFF, 1'b1, 9);
    do_op("lsl_sat",   2'b00, 8'h01, 8'd8,   8'h00, 1'b1, 9);

    // START while busy is ignored
    start_op(2'b01, 8'h90, 8'd3);
    bus.START = 1'b1; bus.SHIFT_OP = 2'b00; bus.OPERAND = 8'hFF; bus.SHIFT_AMOUNT = 8'd1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_check("ignore_start", 1, 8'h12, 1'b0, 4);

    // START held in the DONE cycle is accepted with no IDLE gap
    do_op("b2b_first", 2'b00, 8'h03, 8'd1, 8'h06, 1'b0, 2);
    bus.START = 1'b1; bus.SHIFT_OP = 2'b11; bus.OPERAND = 8'h03; bus.SHIFT_AMOUNT = 8'd1;
    @(negedge CLK);
    bus.START = 1'b0;
    check("b2b_busy_next", 32'(bus.BUSY), 32'h1);
    wait_check("b2b_second", 0, 8'h81, 1'b1, 2);

    // RESET two cycles into an LSL by 5
    start_op(2'b00, 8'h13, 8'd5);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_mid_result", 32'(bus.RESULT), 32'h0);
    check("rst_mid_flags", 32'({bus.CARRY, bus.BUSY, bus.DONE}), 32'h0);
    done_cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.DONE) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'h0);
    do_op("after_rst", 2'b00, 8'h01, 8'd2, 8'h04, 1'b0, 3);

    // randomized traffic, checked cycle-by-cycle by the monitor
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      bus.START = ($urandom_range(0, 3) == 0);
      bus.SHIFT_OP = 2'($urandom);
      bus.OPERAND = 8'($urandom);
      bus.SHIFT_AMOUNT = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      RESET = ($urandom_range(0, 299) == 0);
    end
    @(negedge CLK);
    bus.START = 1'b0;
    RESET = 1'b0;
    repeat (20) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
